imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Pipelined, parametrised immediate generator for the decode stage. Classifies each
//  32-bit instruction as I/S/B/U/J/NONE, sign-extends the immediate to XLEN, and
//  registers it behind valid/ready handshakes with a 2-entry skid buffer. Adds full
//  B/U/J support, flush and backpressure over the older single-cycle combinational ImmGen.
// PARAMETERS
//  XLEN   64  output immediate width; legal values 32 or 64 (elaboration error otherwise)
// PORTS
//  clk         in   1     single clock, all state on rising edge
//  reset       in   1     synchronous, active-high
//  flush       in   1     discard all held entries (branch mispredict / trap)
//  in_valid    in   1     upstream instruction valid
//  in_ready    out  1     block can accept this cycle
//  in_instr    in   32    raw instruction word
//  out_valid   out  1     imm_data/imm_fmt/out_instr valid
//  out_ready   in   1     downstream accepts this cycle
//  out_instr   out  32    instruction passed through, aligned with imm_data
//  imm_data    out  XLEN  sign-extended immediate
//  imm_fmt     out  3     format code (imm_gen_pkg::imm_fmt_t)
//  illegal     out  1     only with IMMGEN_ILLEGAL_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (sync, high): out_valid=0, skid empty, in_ready=1, imm_data=0, imm_fmt=NONE,
//    out_instr=0, illegal=0. Reset mid-stream drops every held entry; no partial output.
//  - Opcode [6:0] map: 0000011,0010011,0011011,1100111 -> I; 0100011 -> S; 1100011 -> B;
//    0110111,0010111 -> U; 1101111 -> J; anything else -> NONE with imm_data=0.
//  - I: instr[31:20]. S: {instr[31:25],instr[11:7]}. B: {instr[31],instr[7],instr[30:25],
//    instr[11:8],1'b0}. U: {instr[31:12],12'b0}. J: {instr[31],instr[19:12],instr[20],
//    instr[30:21],1'b0}. All sign-extended from instr[31] to XLEN (U too, even at XLEN=64).
//    Shift-immediates get the raw I field; no shamt masking.
//  - Transfer occurs when valid&&ready on a port. Latency: accepted instr appears on outputs
//    the next cycle if the output register is empty or draining.
//  - Output register + skid register. in_ready = !skid_valid (registered, no comb path from
//    out_ready). If input accepted while out_valid&&!out_ready, new entry goes to skid.
//    When output drains and skid full, skid moves to output; in_ready returns high the
//    cycle after. Order strictly preserved; no drop, no duplicate.
//  - Simultaneous accept + drain with skid empty: new entry loads output register directly.
//  - flush: next cycle out_valid=0, skid empty, in_ready=1; an in_valid beat in the flush
//    cycle is discarded. flush has priority over every transfer; reset over flush.
//  - Outputs hold stable while out_valid&&!out_ready.
// CONFIGURATION
//  IMMGEN_ILLEGAL_EN defined: port 'illegal' exists; 1 with the entry whose opcode maps to
//    NONE or whose instr[1:0]!=2'b11; flows through the pipeline with its entry.
//  Not defined: port absent; NONE opcodes still produce imm_fmt=NONE, imm_data=0.
// STRUCTURE
//  imm_gen_pkg: typedef enum logic [2:0] imm_fmt_t {FMT_NONE,FMT_I,FMT_S,FMT_B,FMT_U,FMT_J};
//    opcode localparams (OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_JALR, OPC_STORE, OPC_BRANCH,
//    OPC_LUI, OPC_AUIPC, OPC_JAL).
//  Sub-module imm_decode: pure combinational instr -> {imm_fmt, imm_data, illegal}, XLEN
//    param; instantiated once at the input side, result stored in output/skid regs.
// TESTING
//  1 XLEN=64, 0xFFF00093 (addi x1,x0,-1) -> next cycle imm_data=0xFFFF_FFFF_FFFF_FFFF, FMT_I.
//  2 Stream 0xFE112E23 (sw -4) -> 0x...FFFC FMT_S; 0xFE000CE3 (beq -8) -> 0x...FFF8 FMT_B;
//    0x001000EF (jal +2048) -> 0x800 FMT_J; 0x800002B7 (lui) -> 0xFFFF_FFFF_8000_0000 FMT_U.
//  3 Backpressure: back-to-back in_valid, out_ready=0 for 3 cycles -> in_ready drops after
//    2nd accept, outputs stable, then all entries emerge in order, none lost/duplicated.
//  4 flush with output+skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1,
//    flushed entries and flush-cycle input never appear.
//  5 reset asserted mid-stream with skid full -> next cycle all outputs at reset values;
//    first post-reset instr emerges with 1-cycle latency.
//  6 XLEN=32 build, 0x123452B7 -> 0x1234_5000; with IMMGEN_ILLEGAL_EN, 0x0000_0000 ->
//    FMT_NONE, imm_data=0, illegal=1.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// ----------------------------------------------------------------------------
// imm_gen_pkg
// Shared types and constants for the pipelined immediate generator.
//   imm_fmt_t : immediate format code carried alongside every entry
//   OPC_*     : major opcodes (instr[6:0]) that carry an immediate
//   fmt_of()  : opcode -> immediate format classification
// Optional feature macro used by the users of this package: IMMGEN_ILLEGAL_EN
// ----------------------------------------------------------------------------
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;

    function automatic imm_fmt_t fmt_of(input logic [6:0] opc);
        imm_fmt_t f;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_JALR: f = FMT_I;
            OPC_STORE:                                    f = FMT_S;
            OPC_BRANCH:                                   f = FMT_B;
            OPC_LUI, OPC_AUIPC:                           f = FMT_U;
            OPC_JAL:                                      f = FMT_J;
            default:                                      f = FMT_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// ----------------------------------------------------------------------------
// imm_gen_pipe_if
// Valid/ready bus of the immediate generator: instruction input side and
// decoded-immediate output side.
//   master : upstream/downstream environment (drives in_*, out_ready)
//   slave  : imm_gen_pipe (drives in_ready and all out_* / imm_* signals)
// 'illegal' exists only when IMMGEN_ILLEGAL_EN is defined.
// ----------------------------------------------------------------------------
interface imm_gen_pipe_if #(parameter int XLEN = 64);
    import imm_gen_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] imm_data;
    imm_fmt_t        imm_fmt;
`ifdef IMMGEN_ILLEGAL_EN
    logic            illegal;
`endif

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_instr, imm_data, imm_fmt
`ifdef IMMGEN_ILLEGAL_EN
        , input illegal
`endif
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_instr, imm_data, imm_fmt
`ifdef IMMGEN_ILLEGAL_EN
        , output illegal
`endif
    );

endinterface

// File: rtl/imm_decode.sv
// ----------------------------------------------------------------------------
// imm_decode
// Pure combinational immediate decoder.
//   instr_i   [31:0]  raw instruction word
//   fmt_o     [2:0]   immediate format (FMT_NONE for opcodes without one)
//   imm_o     [XLEN]  immediate sign-extended from instr[31]; 0 for FMT_NONE
//   illegal_o         (IMMGEN_ILLEGAL_EN only) NONE opcode or instr[1:0] != 2'b11
// ----------------------------------------------------------------------------
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr_i,
    output imm_fmt_t        fmt_o,
`ifdef IMMGEN_ILLEGAL_EN
    output logic            illegal_o,
`endif
    output logic [XLEN-1:0] imm_o
);

    imm_fmt_t           fmt;
    logic signed [31:0] raw;

    // Each format is first assembled as a signed 32-bit value; the final
    // size cast then sign-extends it to XLEN (U included).
    always_comb begin
        fmt = fmt_of(instr_i[6:0]);
        raw = '0;
        case (fmt)
            FMT_I: raw = {{20{instr_i[31]}}, instr_i[31:20]};
            FMT_S: raw = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FMT_B: raw = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                          instr_i[30:25], instr_i[11:8], 1'b0};
            FMT_U: raw = {instr_i[31:12], 12'b0};
            FMT_J: raw = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                          instr_i[20], instr_i[30:21], 1'b0};
            default: raw = '0;
        endcase
    end

    assign fmt_o = fmt;
    assign imm_o = XLEN'(raw);

`ifdef IMMGEN_ILLEGAL_EN
    assign illegal_o = (fmt == FMT_NONE) || (instr_i[1:0] != 2'b11);
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// imm_gen_pipe
// Registered immediate generator with valid/ready handshakes and a 2-entry
// (output + skid) buffer.
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high; clears every entry and output
//   flush  : drops all held entries and the input beat of the same cycle
//   bus    : imm_gen_pipe_if.slave (in_valid/in_ready/in_instr,
//            out_valid/out_ready/out_instr/imm_data/imm_fmt[/illegal])
// Parameter XLEN: 32 or 64.
// Optional feature macro: IMMGEN_ILLEGAL_EN adds the 'illegal' flag per entry.
// ----------------------------------------------------------------------------
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    imm_gen_pipe_if.slave  bus
);

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [31:0]     instr;
        imm_fmt_t        fmt;
        logic [XLEN-1:0] imm;
`ifdef IMMGEN_ILLEGAL_EN
        logic            ill;
`endif
    } entry_t;

    entry_t new_entry;
    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   accept;
    logic   drain;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr_i   (bus.in_instr),
        .fmt_o     (new_entry.fmt),
`ifdef IMMGEN_ILLEGAL_EN
        .illegal_o (new_entry.ill),
`endif
        .imm_o     (new_entry.imm)
    );
    assign new_entry.instr = bus.in_instr;

    // in_ready depends only on the skid flag, so there is no combinational
    // path from out_ready back to in_ready.
    assign accept = bus.in_valid && !skid_valid_q;
    assign drain  = out_valid_q && bus.out_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || drain) begin
            // Output slot frees up: the older skid entry wins over new input.
            // While the skid is full in_ready is low, so no accept can coincide.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = new_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            // Output stalled: park the new entry in the skid register.
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.in_ready  = !skid_valid_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_q.instr;
    assign bus.imm_data  = out_q.imm;
    assign bus.imm_fmt   = out_q.fmt;
`ifdef IMMGEN_ILLEGAL_EN
    assign bus.illegal   = out_q.ill;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(64)) bus ();
    imm_gen_pipe_if #(.XLEN(32)) bus32 ();

    assign bus32.in_valid  = bus.in_valid;
    assign bus32.in_instr  = bus.in_instr;
    assign bus32.out_ready = bus.out_ready;

    imm_gen_pipe #(.XLEN(64)) u_dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    imm_gen_pipe #(.XLEN(32)) u_dut32 (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus32)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: immediate value computed arithmetically from the field rules.
    function automatic void ref_dec(input logic [31:0] w, output imm_fmt_t f,
                                    output logic [63:0] imm);
        longint s;
        longint v;
        s = longint'($signed(w));
        v = 0;
        f = FMT_NONE;
        case (w[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
                f = FMT_I; v = s >>> 20;
            end
            7'b0100011: begin
                f = FMT_S; v = (s >>> 25) * 32 + longint'(w[11:7]);
            end
            7'b1100011: begin
                f = FMT_B;
                v = (s >>> 31) * 4096 + longint'(w[7]) * 2048
                  + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
            end
            7'b0110111, 7'b0010111: begin
                f = FMT_U; v = (s >>> 12) * 4096;
            end
            7'b1101111: begin
                f = FMT_J;
                v = (s >>> 31) * 1048576 + longint'(w[19:12]) * 4096
                  + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
            end
            default: ;
        endcase
        imm = v;
    endfunction

    // One clock: note handshakes before the edge, update the model after it,
    // then compare every visible output against the model.
    task automatic cycle();
        bit acc;
        bit drn;
        imm_fmt_t    f;
        logic [63:0] imm;
        logic [31:0] w;
        acc = bus.in_valid && bus.in_ready;
        drn = bus.out_valid && bus.out_ready;
        @(posedge clk);
        #1;
        if (reset || flush) begin
            q.delete();
        end else begin
            if (drn && q.size() > 0) void'(q.pop_front());
            if (acc) q.push_back(bus.in_instr);
        end
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
        chk("out_valid32", 64'(bus32.out_valid), 64'(q.size() > 0));
        if (reset) begin
            chk("rst_imm", bus.imm_data, 64'd0);
            chk("rst_fmt", 64'(bus.imm_fmt), 64'(FMT_NONE));
            chk("rst_instr", 64'(bus.out_instr), 64'd0);
            chk("rst_imm32", 64'(bus32.imm_data), 64'd0);
`ifdef IMMGEN_ILLEGAL_EN
            chk("rst_illegal", 64'(bus.illegal), 64'd0);
`endif
        end else if (q.size() > 0) begin
            w = q[0];
            ref_dec(w, f, imm);
            chk("out_instr", 64'(bus.out_instr), 64'(w));
            chk("imm_data", bus.imm_data, imm);
            chk("imm_fmt", 64'(bus.imm_fmt), 64'(f));
            chk("imm_data32", 64'(bus32.imm_data), 64'(imm[31:0]));
`ifdef IMMGEN_ILLEGAL_EN
            chk("illegal", 64'(bus.illegal),
                64'((f == FMT_NONE) || (w[1:0] != 2'b11)));
`endif
        end
    endtask

    logic [6:0] opcs [9] = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111,
                             7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                             7'b1101111};
    logic [31:0] t2_instr [4] = '{32'hFE112E23, 32'hFE000CE3, 32'h001000EF, 32'h800002B7};
    logic [63:0] t2_imm   [4] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF8,
                                  64'h0000_0000_0000_0800, 64'hFFFF_FFFF_8000_0000};
    imm_fmt_t    t2_fmt   [4] = '{FMT_S, FMT_B, FMT_J, FMT_U};

    initial begin
        logic [31:0] r;
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'h0;
        bus.out_ready = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // addi x1,x0,-1
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'hFFF00093;
        cycle();
        chk("t1_imm", bus.imm_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t1_fmt", 64'(bus.imm_fmt), 64'(FMT_I));

        // Streamed S/B/J/U, one per cycle
        for (int i = 0; i < 4; i++) begin
            bus.in_instr = t2_instr[i];
            cycle();
            chk("t2_imm", bus.imm_data, t2_imm[i]);
            chk("t2_fmt", 64'(bus.imm_fmt), 64'(t2_fmt[i]));
        end
        bus.in_valid = 1'b0;
        cycle();

        // Backpressure: three stalled cycles with back-to-back input
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_instr = {12'(i + 1), 13'h0, 7'b0010011};
            cycle();
            if (i == 1) chk("t3_in_ready_low", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Flush with output + skid full and a beat on the input
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h00500013;
        cycle();
        bus.in_instr  = 32'h00600013;
        cycle();
        flush = 1'b1;
        bus.in_instr  = 32'h00700013;
        cycle();
        chk("t4_out_valid", 64'(bus.out_valid), 64'd0);
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Reset mid-stream with skid full, then 1-cycle latency after reset
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h12300093;
        cycle();
        bus.in_instr  = 32'h45600093;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_instr  = 32'h7FF00093;
        cycle();
        chk("t5_imm", bus.imm_data, 64'h0000_0000_0000_07FF);
        bus.in_valid = 1'b0;
        cycle();

        // XLEN=32 LUI and an all-zero word
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h123452B7;
        cycle();
        chk("t6_imm32", 64'(bus32.imm_data), 64'h1234_5000);
        bus.in_instr = 32'h0000_0000;
        cycle();
        chk("t6_none_fmt", 64'(bus32.imm_fmt), 64'(FMT_NONE));
        chk("t6_none_imm", 64'(bus32.imm_data), 64'd0);
`ifdef IMMGEN_ILLEGAL_EN
        chk("t6_illegal", 64'(bus32.illegal), 64'd1);
`endif
        bus.in_valid = 1'b0;
        cycle();

        // Random traffic with occasional flush/reset
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            if ($urandom_range(0, 3) != 0) r[6:0] = opcs[$urandom_range(0, 8)];
            bus.in_instr  = r;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            flush         = ($urandom_range(0, 29) == 0);
            reset         = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 1'b0;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
